// File: rtl/pzcorebus_channel_buffer.sv
// Corebus buffering stage: independent command, write-data and response FIFOs
// with registered accepts, plus a limiter on outstanding non-posted commands.
module pzcorebus_channel_buffer #(
    parameter int CMD_WIDTH       = 64,
    parameter int DATA_WIDTH      = 72,
    parameter int RESP_WIDTH      = 80,
    parameter int CMD_DEPTH       = 4,
    parameter int DATA_DEPTH      = 8,
    parameter int RESP_DEPTH      = 8,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst_n,
    input  logic                                     i_s_cmd_valid,
    output logic                                     o_s_cmd_accept,
    input  logic [CMD_WIDTH-1:0]                     i_s_cmd,
    input  logic                                     i_s_cmd_non_posted,
    input  logic                                     i_s_data_valid,
    output logic                                     o_s_data_accept,
    input  logic [DATA_WIDTH-1:0]                    i_s_data,
    input  logic                                     i_s_data_last,
    output logic                                     o_s_resp_valid,
    input  logic                                     i_s_resp_accept,
    output logic [RESP_WIDTH-1:0]                    o_s_resp,
    output logic                                     o_s_resp_last,
    output logic                                     o_m_cmd_valid,
    input  logic                                     i_m_cmd_accept,
    output logic [CMD_WIDTH-1:0]                     o_m_cmd,
    output logic                                     o_m_cmd_non_posted,
    output logic                                     o_m_data_valid,
    input  logic                                     i_m_data_accept,
    output logic [DATA_WIDTH-1:0]                    o_m_data,
    output logic                                     o_m_data_last,
    input  logic                                     i_m_resp_valid,
    output logic                                     o_m_resp_accept,
    input  logic [RESP_WIDTH-1:0]                    i_m_resp,
    input  logic                                     i_m_resp_last,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     o_outstanding,
    output logic                                     o_underflow
);
    localparam int CPW = $clog2(CMD_DEPTH);
    localparam int CCW = $clog2(CMD_DEPTH + 1);
    localparam int DPW = $clog2(DATA_DEPTH);
    localparam int DCW = $clog2(DATA_DEPTH + 1);
    localparam int RPW = $clog2(RESP_DEPTH);
    localparam int RCW = $clog2(RESP_DEPTH + 1);
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

    // ---------------- command FIFO (non_posted bit stored as MSB) ----------------
    logic [CMD_WIDTH:0] cmd_mem [CMD_DEPTH];
    logic [CPW-1:0]     cmd_wr_ptr, cmd_rd_ptr;
    logic [CCW-1:0]     cmd_cnt, cmd_cnt_nxt;
    logic               cmd_accept, cmd_push, cmd_pop, cmd_nempty, cmd_allowed;
    logic [CMD_WIDTH:0] cmd_head;

    assign cmd_push   = i_s_cmd_valid & cmd_accept;
    assign cmd_pop    = o_m_cmd_valid & i_m_cmd_accept;
    assign cmd_nempty = (cmd_cnt != '0);
    assign cmd_head   = cmd_mem[cmd_rd_ptr];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cmd_cnt_nxt = cmd_cnt;
        if (cmd_push && !cmd_pop)      cmd_cnt_nxt = cmd_cnt + CCW'(1);
        else if (!cmd_push && cmd_pop) cmd_cnt_nxt = cmd_cnt - CCW'(1);
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_cnt    <= '0;
            cmd_accept <= 1'b0;
        end else begin
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + CPW'(1);
            if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + CPW'(1);
            cmd_cnt    <= cmd_cnt_nxt;
            cmd_accept <= (cmd_cnt_nxt != CCW'(CMD_DEPTH));
        end
    end

    // NOTE: storage arrays are not reset; occupancy counters alone define which entries are live.
    always_ff @(posedge i_clk) begin
        if (cmd_push) cmd_mem[cmd_wr_ptr] <= {i_s_cmd_non_posted, i_s_cmd};
    end

    // Outstanding only drops without a command issue, so a presented head stays allowed.
    assign cmd_allowed        = !cmd_head[CMD_WIDTH] || (o_outstanding < OW'(MAX_OUTSTANDING));
    assign o_s_cmd_accept     = cmd_accept;
    assign o_m_cmd_valid      = cmd_nempty & cmd_allowed;
    assign o_m_cmd            = cmd_nempty ? cmd_head[CMD_WIDTH-1:0] : '0;
    assign o_m_cmd_non_posted = cmd_nempty ? cmd_head[CMD_WIDTH] : 1'b0;

    // ---------------- write-data FIFO (last bit stored as MSB) ----------------
    logic [DATA_WIDTH:0] data_mem [DATA_DEPTH];
    logic [DPW-1:0]      data_wr_ptr, data_rd_ptr;
    logic [DCW-1:0]      data_cnt, data_cnt_nxt;
    logic                data_accept, data_push, data_pop, data_nempty;
    logic [DATA_WIDTH:0] data_head;

    assign data_push   = i_s_data_valid & data_accept;
    assign data_pop    = o_m_data_valid & i_m_data_accept;
    assign data_nempty = (data_cnt != '0);
    assign data_head   = data_mem[data_rd_ptr];

    always_comb begin
        data_cnt_nxt = data_cnt;
        if (data_push && !data_pop)      data_cnt_nxt = data_cnt + DCW'(1);
        else if (!data_push && data_pop) data_cnt_nxt = data_cnt - DCW'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_wr_ptr <= '0;
            data_rd_ptr <= '0;
            data_cnt    <= '0;
            data_accept <= 1'b0;
        end else begin
            if (data_push) data_wr_ptr <= data_wr_ptr + DPW'(1);
            if (data_pop)  data_rd_ptr <= data_rd_ptr + DPW'(1);
            data_cnt    <= data_cnt_nxt;
            data_accept <= (data_cnt_nxt != DCW'(DATA_DEPTH));
        end
    end

    always_ff @(posedge i_clk) begin
        if (data_push) data_mem[data_wr_ptr] <= {i_s_data_last, i_s_data};
    end

    assign o_s_data_accept = data_accept;
    assign o_m_data_valid  = data_nempty;
    assign o_m_data        = data_nempty ? data_head[DATA_WIDTH-1:0] : '0;
    assign o_m_data_last   = data_nempty ? data_head[DATA_WIDTH] : 1'b0;

    // ---------------- response FIFO (last bit stored as MSB) ----------------
    logic [RESP_WIDTH:0] resp_mem [RESP_DEPTH];
    logic [RPW-1:0]      resp_wr_ptr, resp_rd_ptr;
    logic [RCW-1:0]      resp_cnt, resp_cnt_nxt;
    logic                resp_accept, resp_push, resp_pop, resp_nempty;
    logic [RESP_WIDTH:0] resp_head;

    assign resp_push   = i_m_resp_valid & resp_accept;
    assign resp_pop    = o_s_resp_valid & i_s_resp_accept;
    assign resp_nempty = (resp_cnt != '0);
    assign resp_head   = resp_mem[resp_rd_ptr];

    always_comb begin
        resp_cnt_nxt = resp_cnt;
        if (resp_push && !resp_pop)      resp_cnt_nxt = resp_cnt + RCW'(1);
        else if (!resp_push && resp_pop) resp_cnt_nxt = resp_cnt - RCW'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            resp_wr_ptr <= '0;
            resp_rd_ptr <= '0;
            resp_cnt    <= '0;
            resp_accept <= 1'b0;
        end else begin
            if (resp_push) resp_wr_ptr <= resp_wr_ptr + RPW'(1);
            if (resp_pop)  resp_rd_ptr <= resp_rd_ptr + RPW'(1);
            resp_cnt    <= resp_cnt_nxt;
            resp_accept <= (resp_cnt_nxt != RCW'(RESP_DEPTH));
        end
    end

    always_ff @(posedge i_clk) begin
        if (resp_push) resp_mem[resp_wr_ptr] <= {i_m_resp_last, i_m_resp};
    end

    assign o_m_resp_accept = resp_accept;
    assign o_s_resp_valid  = resp_nempty;
    assign o_s_resp        = resp_nempty ? resp_head[RESP_WIDTH-1:0] : '0;
    assign o_s_resp_last   = resp_nempty ? resp_head[RESP_WIDTH] : 1'b0;

    // ---------------- outstanding non-posted limiter ----------------
    logic cnt_inc, cnt_dec;

    assign cnt_inc = cmd_pop & cmd_head[CMD_WIDTH];
    assign cnt_dec = resp_push & i_m_resp_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_outstanding <= '0;
            o_underflow   <= 1'b0;
        end else if (cnt_inc && !cnt_dec) begin
            o_outstanding <= o_outstanding + OW'(1);
        end else if (cnt_dec && !cnt_inc) begin
            if (o_outstanding == '0) o_underflow   <= 1'b1;
            else                     o_outstanding <= o_outstanding - OW'(1);
        end
    end

endmodule

// File: tb/tb_pzcorebus_channel_buffer.sv
// Self-checking bench: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pzcorebus_channel_buffer;
    localparam int CW = 64;
    localparam int DW = 72;
    localparam int RW = 80;
    localparam int CD = 4;
    localparam int DD = 8;
    localparam int RD = 8;
    localparam int MO = 2;
    localparam int OW = $clog2(MO + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_s_cmd_valid = 1'b0, i_s_cmd_non_posted = 1'b0;
    logic [CW-1:0] i_s_cmd = '0;
    logic          i_s_data_valid = 1'b0, i_s_data_last = 1'b0;
    logic [DW-1:0] i_s_data = '0;
    logic          i_s_resp_accept = 1'b0;
    logic          i_m_cmd_accept = 1'b0, i_m_data_accept = 1'b0;
    logic          i_m_resp_valid = 1'b0, i_m_resp_last = 1'b0;
    logic [RW-1:0] i_m_resp = '0;
    logic          o_s_cmd_accept, o_s_data_accept, o_s_resp_valid, o_s_resp_last;
    logic [RW-1:0] o_s_resp;
    logic          o_m_cmd_valid, o_m_cmd_non_posted, o_m_data_valid, o_m_data_last, o_m_resp_accept;
    logic [CW-1:0] o_m_cmd;
    logic [DW-1:0] o_m_data;
    logic [OW-1:0] o_outstanding;
    logic          o_underflow;

    pzcorebus_channel_buffer #(
        .CMD_WIDTH(CW), .DATA_WIDTH(DW), .RESP_WIDTH(RW),
        .CMD_DEPTH(CD), .DATA_DEPTH(DD), .RESP_DEPTH(RD), .MAX_OUTSTANDING(MO)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_s_cmd_valid(i_s_cmd_valid), .o_s_cmd_accept(o_s_cmd_accept),
        .i_s_cmd(i_s_cmd), .i_s_cmd_non_posted(i_s_cmd_non_posted),
        .i_s_data_valid(i_s_data_valid), .o_s_data_accept(o_s_data_accept),
        .i_s_data(i_s_data), .i_s_data_last(i_s_data_last),
        .o_s_resp_valid(o_s_resp_valid), .i_s_resp_accept(i_s_resp_accept),
        .o_s_resp(o_s_resp), .o_s_resp_last(o_s_resp_last),
        .o_m_cmd_valid(o_m_cmd_valid), .i_m_cmd_accept(i_m_cmd_accept),
        .o_m_cmd(o_m_cmd), .o_m_cmd_non_posted(o_m_cmd_non_posted),
        .o_m_data_valid(o_m_data_valid), .i_m_data_accept(i_m_data_accept),
        .o_m_data(o_m_data), .o_m_data_last(o_m_data_last),
        .i_m_resp_valid(i_m_resp_valid), .o_m_resp_accept(o_m_resp_accept),
        .i_m_resp(i_m_resp), .i_m_resp_last(i_m_resp_last),
        .o_outstanding(o_outstanding), .o_underflow(o_underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [CW:0] mq_cmd [$];
    logic [DW:0] mq_data [$];
    logic [RW:0] mq_resp [$];
    int          m_cnt = 0;
    bit          m_uf = 1'b0;
    bit          m_cmd_acc = 1'b0, m_data_acc = 1'b0, m_resp_acc = 1'b0;
    bit          mc_push, mc_pop, md_push, md_pop, mr_push, mr_pop, m_inc, m_dec;

    function automatic bit m_cmd_valid();
        if (mq_cmd.size() == 0) return 1'b0;
        return !mq_cmd[0][CW] || (m_cnt < MO);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq_cmd.delete();
            mq_data.delete();
            mq_resp.delete();
            m_cnt = 0;
            m_uf = 1'b0;
            m_cmd_acc = 1'b0;
            m_data_acc = 1'b0;
            m_resp_acc = 1'b0;
        end else begin
            mc_push = i_s_cmd_valid && m_cmd_acc;
            mc_pop  = m_cmd_valid() && i_m_cmd_accept;
            m_inc   = mc_pop && mq_cmd[0][CW];
            md_push = i_s_data_valid && m_data_acc;
            md_pop  = (mq_data.size() > 0) && i_m_data_accept;
            mr_push = i_m_resp_valid && m_resp_acc;
            mr_pop  = (mq_resp.size() > 0) && i_s_resp_accept;
            m_dec   = mr_push && i_m_resp_last;
            if (mc_pop)  void'(mq_cmd.pop_front());
            if (mc_push) mq_cmd.push_back({i_s_cmd_non_posted, i_s_cmd});
            if (md_pop)  void'(mq_data.pop_front());
            if (md_push) mq_data.push_back({i_s_data_last, i_s_data});
            if (mr_pop)  void'(mq_resp.pop_front());
            if (mr_push) mq_resp.push_back({i_m_resp_last, i_m_resp});
            if (m_inc && !m_dec) m_cnt++;
            else if (m_dec && !m_inc) begin
                if (m_cnt == 0) m_uf = 1'b1;
                else            m_cnt--;
            end
            m_cmd_acc  = mq_cmd.size() < CD;
            m_data_acc = mq_data.size() < DD;
            m_resp_acc = mq_resp.size() < RD;
        end
    end

    // Compare every cycle, half a period away from the active edge.
    always @(negedge clk) begin
        check("s_cmd_accept", o_s_cmd_accept, m_cmd_acc);
        check("m_cmd_valid", o_m_cmd_valid, m_cmd_valid());
        if (m_cmd_valid()) check("m_cmd_payload", {o_m_cmd_non_posted, o_m_cmd}, mq_cmd[0]);
        check("s_data_accept", o_s_data_accept, m_data_acc);
        check("m_data_valid", o_m_data_valid, mq_data.size() > 0);
        if (mq_data.size() > 0) check("m_data_payload", {o_m_data_last, o_m_data}, mq_data[0]);
        check("m_resp_accept", o_m_resp_accept, m_resp_acc);
        check("s_resp_valid", o_s_resp_valid, mq_resp.size() > 0);
        if (mq_resp.size() > 0) check("s_resp_payload", {o_s_resp_last, o_s_resp}, mq_resp[0]);
        check("outstanding", o_outstanding, m_cnt);
        check("underflow", o_underflow, m_uf);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [CW-1:0] d, input logic np);
        i_s_cmd_valid = 1'b1;
        i_s_cmd = d;
        i_s_cmd_non_posted = np;
        tick();
        i_s_cmd_valid = 1'b0;
    endtask

    task automatic send_resp(input logic [RW-1:0] d, input logic last);
        i_m_resp_valid = 1'b1;
        i_m_resp = d;
        i_m_resp_last = last;
        tick();
        i_m_resp_valid = 1'b0;
        i_m_resp_last = 1'b0;
    endtask

    bit acc, c_hs, d_hs, r_hs;
    int k;

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_s_cmd_accept", o_s_cmd_accept, 0);
        check("rst_m_resp_accept", o_m_resp_accept, 0);
        check("rst_m_cmd", o_m_cmd, 0);
        check("rst_s_resp", o_s_resp, 0);
        check("rst_outstanding", o_outstanding, 0);
        rst_n = 1'b1;
        tick();
        check("accepts_after_release", {o_s_cmd_accept, o_s_data_accept, o_m_resp_accept}, 3'b111);
        i_s_resp_accept = 1'b1;

        // Single non-posted command
        push_cmd(64'h1234, 1'b1);
        check("first_cmd_valid", o_m_cmd_valid, 1);
        check("first_cmd_payload", o_m_cmd, 64'h1234);
        i_m_cmd_accept = 1'b1;
        tick();
        i_m_cmd_accept = 1'b0;
        check("first_cmd_outstanding", o_outstanding, 1);

        // Issue and final response in the same cycle at count 1
        push_cmd(64'h2, 1'b1);
        i_m_cmd_accept = 1'b1;
        i_m_resp_valid = 1'b1;
        i_m_resp_last = 1'b1;
        i_m_resp = 80'hAA;
        tick();
        i_m_cmd_accept = 1'b0;
        i_m_resp_valid = 1'b0;
        i_m_resp_last = 1'b0;
        check("simul_inc_dec", o_outstanding, 1);
        check("resp_payload", {o_s_resp_valid, o_s_resp_last, o_s_resp}, {2'b11, 80'hAA});
        send_resp(80'hB1, 1'b1);
        check("count_drained", o_outstanding, 0);

        // Limiter with MAX_OUTSTANDING=2
        i_m_cmd_accept = 1'b1;
        i_s_cmd_non_posted = 1'b1;
        i_s_cmd_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            i_s_cmd = CW'(64'hA0 + j);
            tick();
        end
        i_s_cmd_valid = 1'b0;
        check("limit_held", o_m_cmd_valid, 0);
        check("limit_count", o_outstanding, 2);
        push_cmd(64'hB0, 1'b0);
        check("posted_behind_blocked", o_m_cmd_valid, 0);
        send_resp(80'hC1, 1'b1);
        check("limit_release", {o_m_cmd_valid, o_m_cmd}, {1'b1, 64'hA2});
        tick();
        check("posted_after_np", {o_m_cmd_valid, o_m_cmd_non_posted, o_m_cmd}, {2'b10, 64'hB0});
        check("posted_no_count", o_outstanding, 2);
        tick();
        i_m_cmd_accept = 1'b0;
        check("cmd_fifo_empty", o_m_cmd_valid, 0);
        send_resp(80'hC2, 1'b0);
        check("nonlast_no_dec", o_outstanding, 2);
        send_resp(80'hC3, 1'b1);
        send_resp(80'hC4, 1'b1);
        check("count_zero", {o_outstanding, o_underflow}, 0);

        // Underflow
        send_resp(80'hC5, 1'b1);
        check("underflow_set", {o_underflow, o_outstanding}, {1'b1, OW'(0)});
        repeat (2) tick();
        check("underflow_sticky", o_underflow, 1);

        // Full command FIFO
        i_s_cmd_non_posted = 1'b0;
        i_s_cmd_valid = 1'b1;
        i_s_cmd = 64'h10;
        k = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            acc = o_s_cmd_accept;
            tick();
            if (acc) begin
                k++;
                i_s_cmd = CW'(64'h10 + k);
            end
            if (k == 4) check("full_accept_low", o_s_cmd_accept, 0);
        end
        check("full_pushed", k, 4);
        i_m_cmd_accept = 1'b1;
        for (int j = 0; j < 5; j++) begin
            check("full_order", {o_m_cmd_valid, o_m_cmd}, {1'b1, CW'(64'h10 + j)});
            acc = o_s_cmd_accept && i_s_cmd_valid;
            tick();
            if (j == 0) check("accept_reasserts", o_s_cmd_accept, 1);
            if (acc) i_s_cmd_valid = 1'b0;
        end
        check("full_drained", o_m_cmd_valid, 0);
        i_m_cmd_accept = 1'b0;

        // Random traffic on all channels
        for (int cyc = 0; cyc < 4000; cyc++) begin
            c_hs = i_s_cmd_valid && o_s_cmd_accept;
            d_hs = i_s_data_valid && o_s_data_accept;
            r_hs = i_m_resp_valid && o_m_resp_accept;
            tick();
            if (!i_s_cmd_valid || c_hs) begin
                i_s_cmd_valid = ($urandom_range(0, 99) < 60);
                i_s_cmd = {$urandom(), $urandom()};
                i_s_cmd_non_posted = 1'($urandom_range(0, 1));
            end
            if (!i_s_data_valid || d_hs) begin
                i_s_data_valid = ($urandom_range(0, 99) < 60);
                i_s_data = {8'($urandom()), $urandom(), $urandom()};
                i_s_data_last = 1'($urandom_range(0, 1));
            end
            if (!i_m_resp_valid || r_hs) begin
                i_m_resp_valid = ($urandom_range(0, 99) < 45);
                i_m_resp = {16'($urandom()), $urandom(), $urandom()};
                i_m_resp_last = 1'($urandom_range(0, 1));
            end
            i_m_cmd_accept  = ($urandom_range(0, 99) < 50);
            i_m_data_accept = ($urandom_range(0, 99) < 50);
            i_s_resp_accept = ($urandom_range(0, 99) < 50);
        end
        i_s_cmd_valid = 1'b0;
        i_s_data_valid = 1'b0;
        i_m_resp_valid = 1'b0;
        i_m_cmd_accept = 1'b0;
        i_m_data_accept = 1'b0;
        i_s_resp_accept = 1'b0;
        tick();

        // Reset with entries buffered
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int j = 0; j < 3; j++) push_cmd(CW'(64'h50 + j), 1'b0);
        i_s_data_valid = 1'b1;
        i_s_data = 72'h77;
        tick();
        i_s_data_valid = 1'b0;
        check("pre_reset_valids", {o_m_cmd_valid, o_m_data_valid}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("reset_valids_now", {o_m_cmd_valid, o_m_data_valid, o_s_resp_valid}, 3'b000);
        check("reset_accepts_now", {o_s_cmd_accept, o_s_data_accept, o_m_resp_accept}, 3'b000);
        check("reset_counter_now", {o_outstanding, o_underflow}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_empty", {o_m_cmd_valid, o_m_data_valid, o_m_cmd}, 0);
        check("post_reset_accepts", {o_s_cmd_accept, o_s_data_accept, o_m_resp_accept}, 3'b111);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
